// File: rtl/dmem_if.sv
// dmem_if: request/response channel between a pipeline MEM stage (master)
// and a data-memory responder (slave).
//   req_valid/req_ready   : request handshake (master -> slave)
//   req_addr              : byte address of the access
//   req_write             : 1 = store, 0 = load
//   req_wdata             : store data
//   resp_valid/resp_ready : response handshake (slave -> master)
//   resp_rdata            : load data (0 for stores and errors)
//   resp_err              : misaligned or out-of-range access
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory with a fixed access
// latency. One request is in flight at a time; a new request may be accepted
// on the same edge that the current response is consumed.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous reset, active low (does not touch memory contents)
//   bus   : dmem_if slave modport (request and response channels)
//   busy  : high whenever the responder is not idle
module dmem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16384,
    parameter int LATENCY = 4
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus,
    output logic   busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic              load_ok_reg;   // response carries memory read data
    logic [31:0]       mem_q_reg;     // registered memory read port

    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              do_access;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] acc_word;
    logic              acc_write;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;

    // With single-cycle latency the access happens on the acceptance edge,
    // so it must use the live request rather than the latched copy.
    generate
        if (LATENCY == 1) begin : g_direct
            assign acc_addr  = bus.req_addr;
            assign acc_write = bus.req_write;
            assign acc_wdata = bus.req_wdata;
            assign do_access = accept;
        end else begin : g_latched
            assign acc_addr  = addr_reg;
            assign acc_write = write_reg;
            assign acc_wdata = wdata_reg;
            assign do_access = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));
        end
    endgenerate

    assign acc_word = acc_addr >> 2;
    assign acc_idx  = acc_word[IDX_W-1:0];
    assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_word >= ADDR_W'(DEPTH));

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: accept = bus.req_valid;
            WAIT: if (cnt_reg == CNT_W'(1)) state_next = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    if (bus.req_valid) accept = 1'b1;
                    else               state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept) state_next = (LATENCY > 1) ? WAIT : RESP;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= bus.req_addr;
                write_reg <= bus.req_write;
                wdata_reg <= bus.req_wdata;
                cnt_reg   <= CNT_LOAD;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            // Handshake clears the response; a same-edge access overrides.
            if ((state_reg == RESP) && bus.resp_ready) begin
                err_reg     <= 1'b0;
                load_ok_reg <= 1'b0;
            end
            if (do_access) begin
                err_reg     <= acc_err;
                load_ok_reg <= !acc_write && !acc_err;
            end
        end
    end

    // Memory array: no reset so it maps onto block RAM; reset only
    // suppresses a pending access.
    always_ff @(posedge clk) begin
        if (reset && do_access && !acc_err) begin
            if (acc_write) mem[acc_idx] <= acc_wdata;
            else           mem_q_reg    <= mem[acc_idx];
        end
    end

    assign bus.req_ready  = (state_reg == IDLE) || ((state_reg == RESP) && bus.resp_ready);
    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_rdata = load_ok_reg ? mem_q_reg : 32'h0;
    assign bus.resp_err   = err_reg;
    assign busy           = (state_reg != IDLE);
endmodule
